// File: rtl/hero_collision.sv
// hero_collision
//
// Purpose:
//   Builds the 4-bit collision vector used by the hero movement controller.
//   On each start pulse the hero position is snapshotted and the whole block
//   table is scanned through a synchronous-read port. A side is flagged when
//   a valid block sits flush against the hero square on that side and the
//   two squares overlap strictly on the perpendicular axis. Corner-only
//   contact therefore flags nothing.
//
// Bit mapping of collision: [3]=up, [2]=down, [1]=right, [0]=left.
//
// Optional feature:
//   HERO_COLLISION_WALLS_EN - when defined, the arena walls are ORed into the
//   result as the scan completes. When undefined, only blocks contribute.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-low reset
//   start        in   scan request pulse (ignored while busy)
//   hero_x_pos   in   hero top-left x
//   hero_y_pos   in   hero top-left y
//   block_addr   out  block table read address
//   block_x_pos  in   block top-left x, returned one cycle after block_addr
//   block_y_pos  in   block top-left y, same timing as block_x_pos
//   block_valid  in   entry occupied, same timing as block_x_pos
//   collision    out  registered collision flags
//   busy         out  high while a scan is in progress
//   scan_done    out  one-cycle pulse, collision holds the new result
//
// Handshake: start is a single-cycle request sampled only in IDLE; there is
// no acknowledge and no queuing. scan_done marks the one cycle in which the
// freshly loaded collision value is first visible; collision then holds
// until the next scan completes or reset.

module hero_collision #(
   parameter int NUM_BLOCKS   = 150,
   parameter int ADDR_WIDTH   = 8,
   parameter int SQUARE_SIDE  = 60,
   parameter int BLOCK_SIDE   = 60,
   parameter int ARENA_LEFT   = 62,
   parameter int ARENA_TOP    = 108,
   parameter int ARENA_RIGHT  = 962,
   parameter int ARENA_BOTTOM = 708
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [11:0]           hero_x_pos,
   input  logic [11:0]           hero_y_pos,
   output logic [ADDR_WIDTH-1:0] block_addr,
   input  logic [11:0]           block_x_pos,
   input  logic [11:0]           block_y_pos,
   input  logic                  block_valid,
   output logic [3:0]            collision,
   output logic                  busy,
   output logic                  scan_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_BLOCKS - 1);
   localparam logic [12:0]           SQ_SIDE   = 13'(SQUARE_SIDE);
   localparam logic [12:0]           BLK_SIDE  = 13'(BLOCK_SIDE);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [11:0]           hx_q, hx_d;
   logic [11:0]           hy_q, hy_d;
   logic [3:0]            acc_q, acc_d;
   logic [3:0]            coll_q, coll_d;
   // Marks that the data on the block_* inputs answers an address issued
   // during SCAN in the previous cycle.
   logic                  tag_q, tag_d;

   // ------------------------------------------------------------------
   // Per-entry geometry, all in 13 bits so x+side never wraps.
   // ------------------------------------------------------------------
   logic [12:0] hx13, hy13, bx13, by13;
   logic [12:0] h_right, h_bottom, b_right, b_bottom;
   logic        hov, vov;
   logic [3:0]  entry_hit;
   logic [3:0]  wall_c;

   assign hx13     = {1'b0, hx_q};
   assign hy13     = {1'b0, hy_q};
   assign bx13     = {1'b0, block_x_pos};
   assign by13     = {1'b0, block_y_pos};
   assign h_right  = hx13 + SQ_SIDE;
   assign h_bottom = hy13 + SQ_SIDE;
   assign b_right  = bx13 + BLK_SIDE;
   assign b_bottom = by13 + BLK_SIDE;

   assign hov = (bx13 < h_right) && (hx13 < b_right);
   assign vov = (by13 < h_bottom) && (hy13 < b_bottom);

   assign entry_hit[3] = hov && (b_bottom == hy13);  // block directly above
   assign entry_hit[2] = hov && (h_bottom == by13);  // block directly below
   assign entry_hit[1] = vov && (h_right == bx13);   // block directly right
   assign entry_hit[0] = vov && (b_right == hx13);   // block directly left

`ifdef HERO_COLLISION_WALLS_EN
   assign wall_c[3] = (hy13 <= 13'(ARENA_TOP));
   assign wall_c[2] = (h_bottom >= 13'(ARENA_BOTTOM));
   assign wall_c[1] = (h_right >= 13'(ARENA_RIGHT));
   assign wall_c[0] = (hx13 <= 13'(ARENA_LEFT));
`else
   // Walls are not part of this build; the arena geometry is only folded
   // into a constant so the parameters stay referenced.
   localparam bit ARENA_SANE = (ARENA_LEFT < ARENA_RIGHT) && (ARENA_TOP < ARENA_BOTTOM);
   assign wall_c = 4'b0000 & {4{ARENA_SANE}};
`endif

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      hx_d    = hx_q;
      hy_d    = hy_q;
      acc_d   = acc_q;
      coll_d  = coll_q;
      tag_d   = (state_q == SCAN);

      // tag_q is never set in IDLE, so this cannot collide with the clear below.
      if (tag_q && block_valid) begin
         acc_d = acc_q | entry_hit;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               hx_d    = hero_x_pos;
               hy_d    = hero_y_pos;
               acc_d   = 4'b0000;
               addr_d  = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (addr_q == LAST_ADDR) begin
               state_d = DRAIN;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         DRAIN: begin
            // acc_d already includes the last entry evaluated this cycle,
            // so the result is visible during DONE alongside scan_done.
            coll_d  = acc_d | wall_c;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         hx_q    <= 12'd0;
         hy_q    <= 12'd0;
         acc_q   <= 4'b0000;
         coll_q  <= 4'b0000;
         tag_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         hx_q    <= hx_d;
         hy_q    <= hy_d;
         acc_q   <= acc_d;
         coll_q  <= coll_d;
         tag_q   <= tag_d;
      end
   end

   assign block_addr = addr_q;
   assign collision  = coll_q;
   assign busy       = (state_q != IDLE);
   assign scan_done  = (state_q == DONE);

endmodule

// File: tb/tb_hero_collision.sv
// Directed testbench for hero_collision. A behavioural block table answers
// block_addr one cycle later; each scenario loads the table, pulses start
// and checks latency, pulse count, busy and the collision result against
// hand-computed values (plus wall terms when HERO_COLLISION_WALLS_EN is set).

module tb_hero_collision;

   localparam int NUM_BLOCKS = 150;
   localparam int ADDR_WIDTH = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic                  start;
   logic [11:0]           hero_x_pos, hero_y_pos;
   logic [ADDR_WIDTH-1:0] block_addr;
   logic [11:0]           block_x_pos, block_y_pos;
   logic                  block_valid;
   logic [3:0]            collision;
   logic                  busy, scan_done;

   hero_collision #(
      .NUM_BLOCKS (NUM_BLOCKS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .hero_x_pos  (hero_x_pos),
      .hero_y_pos  (hero_y_pos),
      .block_addr  (block_addr),
      .block_x_pos (block_x_pos),
      .block_y_pos (block_y_pos),
      .block_valid (block_valid),
      .collision   (collision),
      .busy        (busy),
      .scan_done   (scan_done)
   );

   // ---------------- block table model (synchronous read) ----------------
   logic [11:0] mem_x [256];
   logic [11:0] mem_y [256];
   logic        mem_v [256];

   always @(posedge clk) begin
      block_x_pos <= mem_x[block_addr];
      block_y_pos <= mem_y[block_addr];
      block_valid <= mem_v[block_addr];
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] wall_exp(input int hx, input int hy);
      logic [3:0] w;
      w = 4'b0000;
`ifdef HERO_COLLISION_WALLS_EN
      w[3] = (hy <= 108);
      w[2] = (hy + 60 >= 708);
      w[1] = (hx + 60 >= 962);
      w[0] = (hx <= 62);
`else
      if (hx < 0 || hy < 0) w = 4'b0000;
`endif
      return w;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic clear_blocks();
      for (int i = 0; i < 256; i++) begin
         mem_x[i] = 12'd0;
         mem_y[i] = 12'd0;
         mem_v[i] = 1'b0;
      end
   endtask

   task automatic set_block(input int idx, input int x, input int y, input logic v);
      mem_x[idx] = 12'(x);
      mem_y[idx] = 12'(y);
      mem_v[idx] = v;
   endtask

   // Pulses start and watches a bounded window. poke_cyc>0 moves the hero
   // and re-pulses start mid-scan; the result must still use the snapshot.
   task automatic run_scan(input string tag, input logic [3:0] exp, input int poke_cyc);
      int          first_done;
      int          pulses;
      logic [11:0] saved_x;
      first_done = 0;
      pulses     = 0;
      saved_x    = hero_x_pos;
      @(negedge clk);
      start = 1'b1;
      for (int cyc = 1; cyc <= NUM_BLOCKS + 6; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            start = 1'b0;
            check_val({tag, "_busy_on"}, 32'(busy), 32'd1);
         end
         if (poke_cyc != 0 && cyc == poke_cyc) begin
            hero_x_pos = 12'd100;
            start      = 1'b1;
         end
         if (poke_cyc != 0 && cyc == poke_cyc + 1) begin
            start = 1'b0;
         end
         if (scan_done) begin
            pulses++;
            if (first_done == 0) first_done = cyc;
         end
      end
      check_val({tag, "_latency"}, 32'(first_done), 32'(NUM_BLOCKS + 2));
      check_val({tag, "_pulses"}, 32'(pulses), 32'd1);
      check_val({tag, "_coll"}, 32'(collision), 32'(exp));
      check_val({tag, "_busy_off"}, 32'(busy), 32'd0);
      hero_x_pos = saved_x;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int aborted_pulses;
      rst        = 1'b0;
      start      = 1'b0;
      hero_x_pos = 12'd481;
      hero_y_pos = 12'd648;
      clear_blocks();

      // Reset state
      repeat (3) @(negedge clk);
      check_val("rst_coll", 32'(collision), 32'd0);
      check_val("rst_done", 32'(scan_done), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_addr", 32'(block_addr), 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check_val("rst_start_busy", 32'(busy), 32'd0);
      check_val("rst_start_done", 32'(scan_done), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Up contact
      set_block(5, 481, 588, 1'b1);
      run_scan("up", 4'b1000 | wall_exp(481, 648), 0);

      // Left (first entry) and right (last entry)
      clear_blocks();
      set_block(0, 421, 648, 1'b1);
      set_block(NUM_BLOCKS - 1, 541, 648, 1'b1);
      run_scan("lr", 4'b0011 | wall_exp(481, 648), 0);
      set_block(77, 481, 708, 1'b1);
      run_scan("lrd", 4'b0111 | wall_exp(481, 648), 0);

      // Corner-only contact and invalid entry
      clear_blocks();
      set_block(NUM_BLOCKS - 1, 541, 588, 1'b1);
      run_scan("corner", 4'b0000 | wall_exp(481, 648), 0);
      clear_blocks();
      set_block(5, 481, 588, 1'b0);
      run_scan("invalid", 4'b0000 | wall_exp(481, 648), 0);

      // Snapshot plus start while busy
      set_block(5, 481, 588, 1'b1);
      run_scan("snap", 4'b1000 | wall_exp(481, 648), 10);

      // Reset mid-scan
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_val("abort_coll", 32'(collision), 32'd0);
      check_val("abort_busy", 32'(busy), 32'd0);
      check_val("abort_addr", 32'(block_addr), 32'd0);
      rst = 1'b1;
      aborted_pulses = 0;
      for (int cyc = 0; cyc < NUM_BLOCKS + 6; cyc++) begin
         @(negedge clk);
         if (scan_done) aborted_pulses++;
      end
      check_val("abort_no_done", 32'(aborted_pulses), 32'd0);
      check_val("abort_coll_hold", 32'(collision), 32'd0);
      run_scan("post_abort", 4'b1000 | wall_exp(481, 648), 0);

      // Walls: hero against top-left corner, no valid blocks
      clear_blocks();
      hero_x_pos = 12'd62;
      hero_y_pos = 12'd108;
`ifdef HERO_COLLISION_WALLS_EN
      run_scan("walls", 4'b1001, 0);
`else
      run_scan("walls", 4'b0000, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
